serial_add_sub_unit: RTL and testbench
======================================

Name: serial_add_sub_unit

Overview:
- Bit-serial signed add/subtract responder. Accepts one (A, B, Opcode) request through a valid/ready handshake and computes one bit per clock, LSB first.
- Returns Sum, Carry and Overflow through a second valid/ready handshake.
- Serves as the sequential, handshaked execution-side counterpart to the stimulus-driving adder benches, and is a drop-in target for multi-cycle ALU experiments.

Parameters:
WIDTH, 8, operand/result width in bits (WIDTH >= 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  request present on A/B/Opcode
in_ready  output  1  unit can accept a request
A  input  WIDTH  signed operand A
B  input  WIDTH  signed operand B
Opcode  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
Sum  output  WIDTH  signed result
Carry  output  1  carry out of MSB
Overflow  output  1  signed overflow flag

Behaviour:
- Reset and clocking:
  - One clock.
  - Reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset overrides all other activity, including mid-operation.
  - After reset: state IDLE, in_ready=1, out_valid=0, Sum=0, Carry=0, Overflow=0, bit counter=0, internal shift registers=0.
- States:
  - IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1, capture A into the operand-A shift register, capture B XOR {WIDTH{Opcode}} into the operand-B shift register, set carry_reg=Opcode, set counter=0, and go to BUSY. With in_valid=0, stay in IDLE.
  - BUSY: in_ready=0, out_valid=0. Each edge:
    - s = a0 ^ b0 ^ carry_reg, where a0 and b0 are the shift-register LSBs.
    - Shift s into the result MSB and shift the operands right.
    - carry_reg <= majority(a0, b0, carry_reg).
    - Record the carry into bit WIDTH-1 on the edge where counter = WIDTH-1.
    - counter++.
    - On the edge processing counter = WIDTH-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. On an edge with out_ready=1, go to IDLE. Otherwise hold.
- Outputs:
  - Sum, Carry and Overflow are registered.
  - They are loaded on the edge that enters DONE: Sum = assembled result, Carry = final carry_reg, Overflow = carry into MSB XOR carry out of MSB.
  - They hold that value until the next DONE entry or reset, including while in IDLE.
  - They are stable throughout DONE regardless of out_ready.
- Latency:
  - Accept edge T. out_valid is visible after edge T+WIDTH, which is WIDTH cycles.
  - Minimum request-to-request spacing is WIDTH+2 cycles when out_ready is held at 1.
- Arithmetic: two's complement modulo 2^WIDTH.
  - Subtract is A + ~B + 1, so Carry=1 means no borrow.
  - Overflow is set iff the true signed result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Boundaries:
  - in_valid during BUSY or DONE is ignored, with no capture. The requester must hold the request until it sees in_ready.
  - A/B/Opcode changing after the accept edge has no effect on the in-flight operation.
  - No accept is possible in the same cycle as the out handshake. IDLE is always passed through for at least one cycle.
  - B = most-negative with Opcode=1 is handled by the same datapath, with no special case.

Test Plan:
- Reset, then A=50, B=60, Opcode=0 with out_ready=1 -> out_valid rises 8 cycles after accept; Sum=110, Carry=0, Overflow=0.
- A=100, B=100, Opcode=1 -> Sum=0, Carry=1, Overflow=0. A=10, B=-125, Opcode=1 -> Sum=-121 (8'h87), Carry=0, Overflow=1.
- A=127, B=127, Opcode=0 -> Sum=-2 (8'hFE), Carry=0, Overflow=1. A=-123, B=-6, Opcode=0 -> Sum=127 (8'h7F), Carry=1, Overflow=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid stays 1, in_ready stays 0, Sum/Carry/Overflow unchanged, and the new request is not captured. Raise out_ready -> IDLE on the next cycle, in_ready=1.
- Change A/B/Opcode on every cycle during BUSY for request A=1, B=2, Opcode=0 -> Sum=3, Carry=0, Overflow=0.
- Assert reset for one cycle at counter=3 of BUSY -> next cycle in_ready=1, out_valid=0, Sum=0, Carry=0, Overflow=0. A fresh request A=0, B=0, Opcode=1 then completes with Sum=0, Carry=1, Overflow=0.

Source files
------------

// File: rtl/serial_add_sub_unit.sv
// serial_add_sub_unit: bit-serial signed add/subtract with valid/ready request and result handshakes
module serial_add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] a, b, res;
  logic [CW-1:0] cnt;
  logic c, s, maj, last;
  assign s    = a[0] ^ b[0] ^ c;
  assign maj  = (a[0] & b[0]) | (a[0] & c) | (b[0] & c);
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    next = state == IDLE ? (in_valid ? BUSY : IDLE) :
           state == BUSY ? (last ? DONE : BUSY) :
           (out_ready ? IDLE : DONE);
  end
  // subtraction is A + ~B + 1: B is inverted on capture and the +1 enters as the initial carry
  always_ff @(posedge clk)
    if (reset) begin
      a <= '0;
      b <= '0;
      res <= '0;
      c <= 1'b0;
      cnt <= '0;
      Sum <= '0;
      Carry <= 1'b0;
      Overflow <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a <= A;
      b <= B ^ {WIDTH{Opcode}};
      c <= Opcode;
      cnt <= '0;
    end else if (state == BUSY) begin
      a <= a >> 1;
      b <= b >> 1;
      res <= {s, res[WIDTH-1:1]};
      c <= maj;
      cnt <= cnt + 1'b1;
      if (last) begin
        Sum <= {s, res[WIDTH-1:1]};
        Carry <= maj;
        Overflow <= c ^ maj;
      end
    end
endmodule

// File: tb/tb_serial_add_sub_unit.sv
// tb_serial_add_sub_unit: random and directed checks against an arithmetic reference model
module tb_serial_add_sub_unit;
  localparam int W = 8;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, Opcode = 0, out_valid, out_ready = 1;
  logic [W-1:0] A = 0, B = 0, Sum;
  logic Carry, Overflow;
  int checks = 0, errors = 0;
  bit started = 0;
  int m_left = 0;
  bit m_valid = 0;
  logic [W+1:0] m_res = '0, p_res = '0;

  serial_add_sub_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Opcode(Opcode), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  // returns {sum, carry, overflow} computed with plain integer arithmetic
  function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    int sa, sb, r;
    longint unsigned u;
    sa = $signed(a);
    sb = $signed(b);
    r = op ? sa - sb : sa + sb;
    u = op ? longint'(a) + longint'((1 << W) - 1 - int'(b)) + 1 : longint'(a) + longint'(b);
    return {W'(r), u[W], (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)))};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'h00;
      3: return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  always @(posedge clk)
    if (reset) begin
      m_left = 0;
      m_valid = 0;
      m_res = '0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1;
        m_res = p_res;
      end
    end else if (in_valid) begin
      p_res = calc(A, B, Opcode);
      m_left = W;
    end

  always @(negedge clk)
    if (started && !reset) begin
      chk("in_ready", 32'(in_ready), 32'(!m_valid && m_left == 0));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("sum", 32'(Sum), 32'(m_res[W+1:2]));
      chk("carry", 32'(Carry), 32'(m_res[1]));
      chk("overflow", 32'(Overflow), 32'(m_res[0]));
    end

  task automatic req(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input bit bp);
    int n = 0, lat = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    in_valid = 1;
    A = a;
    B = b;
    Opcode = op;
    out_ready = !bp;
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && lat < 50) begin
      A = pick();
      B = pick();
      Opcode = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(W));
    if (bp) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = 1;
        A = pick();
        B = pick();
        Opcode = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 0;
      out_ready = 1;
    end
    @(negedge clk);
    chk("idle_after_out", 32'(in_ready), 32'd1);
  endtask

  initial begin
    chk("model_add", 32'(calc(8'd50, 8'd60, 0)), {22'd0, 8'd110, 2'b00});
    chk("model_sub_eq", 32'(calc(8'd100, 8'd100, 1)), {22'd0, 8'd0, 2'b10});
    chk("model_sub_ovf", 32'(calc(8'd10, 8'h83, 1)), {22'd0, 8'h87, 2'b01});
    chk("model_add_ovf", 32'(calc(8'd127, 8'd127, 0)), {22'd0, 8'hFE, 2'b01});
    chk("model_neg_ovf", 32'(calc(8'h85, 8'hFA, 0)), {22'd0, 8'h7F, 2'b11});
    chk("model_zero_sub", 32'(calc(8'd0, 8'd0, 1)), {22'd0, 8'd0, 2'b10});
    chk("model_minneg_sub", 32'(calc(8'd0, 8'h80, 1)), {22'd0, 8'h80, 2'b01});
    repeat (2) @(negedge clk);
    started = 1;
    reset = 0;
    @(negedge clk);
    chk("reset_sum", 32'(Sum), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    req(8'd50, 8'd60, 0, 0);
    chk("sum_50_60", 32'(Sum), 32'd110);
    req(8'd100, 8'd100, 1, 0);
    req(8'd10, 8'h83, 1, 0);
    chk("sum_10_m125", 32'(Sum), 32'h87);
    req(8'd127, 8'd127, 0, 0);
    req(8'h85, 8'hFA, 0, 0);
    req(8'd20, 8'd7, 1, 1);
    req(8'd1, 8'd2, 0, 0);
    chk("sum_1_2", 32'(Sum), 32'd3);
    in_valid = 1;
    A = 8'd33;
    B = 8'd44;
    Opcode = 0;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midreset_ready", 32'(in_ready), 32'd1);
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_flags", 32'({Sum, Carry, Overflow}), 32'd0);
    req(8'd0, 8'd0, 1, 0);
    chk("zero_sub_carry", 32'(Carry), 32'd1);
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      A = pick();
      B = pick();
      Opcode = 1'($urandom);
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
